mdio_phy_resp: RTL and testbench
================================

# mdio_phy_resp

MDIO management responder: the PHY-side end of the clause-22 MDC/MDIO link driven by the team's MDIO master. It oversamples MDC in the system clock domain, decodes preamble/ST/OP/PHYAD/REGAD/TA frames, and serves reads and writes from a small internal register file. It is used as a PHY model in benches and as the management endpoint of the SFP bridge, which has no real copper PHY.

## Interface
- PHY_ADDR, 5'h04: PHY address this block answers to.
- ID1, 16'h001C: value of register 2 (read-only).
- ID2, 16'hC916: value of register 3 (read-only).
- CTRL_RST, 16'h1140: reset value of register 0.

- clk  in  1  system clock; must be at least 8x the MDC frequency.
- rst_n  in  1  asynchronous active-low reset.
- mdc  in  1  MDC from the master; asynchronous, resynchronized internally.
- mdio_i  in  1  MDIO input from the pad; asynchronous, resynchronized internally.
- mdio_o  out  1  MDIO output value.
- mdio_oe  out  1  MDIO output enable; top level builds the tri-state.
- link_up  in  1  reflected in register 1, bit 2.
- speed_sel  in  2  reflected in register 17, bits [15:14].
- ctrl_reg  out  16  current register 0 contents.
- wr_stb  out  1  one-clk pulse per accepted write.
- wr_addr  out  5  register address of the last accepted write.
- wr_data  out  16  data of the last accepted write.

## Operation
- mdc and mdio_i each pass through a 2-FF synchronizer. A registered rising-edge detect on the synchronized mdc produces `rise`. All frame bits are sampled from the synchronized mdio on `rise`.
- Frame bit index n counts `rise` events after preamble: b0–b1 ST, b2–b3 OP, b4–b8 PHYAD, b9–b13 REGAD, b14–b15 TA, b16–b31 DATA (MSB first).
- States:
  - IDLE: a 6-bit counter counts consecutive 1s and saturates at 32; a 0 clears it. A 0 seen with count = 32 goes to ST1; otherwise the block stays in IDLE.
  - ST1: 1 goes to OP; 0 goes to IDLE.
  - OP: collects 2 bits. 10 = read, 01 = write; 00 or 11 goes to IDLE.
  - PHYAD: collects 5 bits; match = (PHYAD == PHY_ADDR).
  - REGAD: collects 5 bits. On the last bit, the read shift register loads the selected register.
  - TA: 2 bits; values are ignored on writes.
  - DATA: 16 bits. Then back to IDLE with the preamble counter cleared.
- Register map:
  - 0: RW, reset CTRL_RST. Bit 15 is self-clearing: writing 1 reloads CTRL_RST and reads back 0.
  - 1: RO, 16'h7809 | (link_up << 2).
  - 2: ID1.
  - 3: ID2.
  - 4–15: RW scratch, reset 0.
  - 17: RO, {speed_sel, 14'h0}.
  - All other addresses read 0; writes to them are ignored.
- Write with match: after bit b31, the register is updated (if writable). wr_stb pulses for 1 clk, and wr_addr/wr_data update, even for RO addresses. No match: no update and no wr_stb.
- Read with match:
  - b14: mdio_oe stays 0.
  - After `rise` of b14: mdio_oe = 1, mdio_o = 0 (TA).
  - After `rise` of b15+k (k = 0..15): mdio_o = data[15−k].
  - After `rise` of b31: mdio_oe = 0.
  - No match: mdio_oe is never asserted.
- A read returns register contents latched at b13. A link_up change during DATA does not alter the word in flight.

## Timing
- Reset values: mdio_oe = 0, mdio_o = 1, ctrl_reg = CTRL_RST, wr_stb = 0, wr_addr = 0, wr_data = 0. Scratch registers = 0, FSM in IDLE, preamble count = 0.
- Latency from an mdc pin edge to `rise`: 3 clk (2 sync + 1 detect).
- mdio_o/mdio_oe update registered 1 clk after `rise`, i.e. 4 clk after the mdc pin edge.
- wr_stb asserts 1 clk after the `rise` of b31. ctrl_reg reflects the write in the same cycle.
- MDC high and low phases must each be at least 4 clk; shorter phases are unsupported.
- rst_n asserted mid-frame: mdio_oe drops asynchronously, the FSM returns to IDLE, and the next frame requires a full 32-bit preamble.
- A master that stops mid-frame (no more `rise` events) leaves the FSM waiting. The frame then completes or aborts on subsequent bits; no timeout is implemented.
- Back-to-back frames each require their own 32-bit preamble. ST seen with fewer than 32 leading 1s is ignored.

## Test plan
- Reset: hold rst_n low, release -> mdio_oe = 0, ctrl_reg = 16'h1140, wr_stb never pulses.
- Read reg 2 at PHYAD 04 after 32×1 preamble -> mdio_oe rises after b14 `rise`, TA = 0, serial data = 16'h001C, mdio_oe = 0 after b31.
- Write 16'h0100 to reg 0, then read reg 0 -> one wr_stb pulse with wr_addr = 0, wr_data = 16'h0100; ctrl_reg = 16'h0100; read returns 16'h0100. Then write 16'h8000 -> ctrl_reg = 16'h1140.
- Read reg 1 with PHYAD 05 -> mdio_oe stays 0 for the entire frame; a write to reg 4 at PHYAD 05 produces no wr_stb and reg 4 reads back 0.
- Preamble of 31 ones, then a valid read frame -> ignored (mdio_oe = 0). OP = 11 after a valid preamble -> abort, and the following valid frame is served.
- rst_n pulsed low during DATA of a read of reg 1 (link_up = 1) -> mdio_oe = 0 immediately; the next full read of reg 1 returns 16'h780D.

Source files
------------

// File: rtl/mdio_phy_resp.sv
// mdio_phy_resp: clause-22 MDIO responder (PHY side).
// MDC and MDIO are oversampled in the clk domain. Frames are decoded and
// served from a small internal register file.
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   mdc, mdio_i         MDC / MDIO from the pad (asynchronous)
//   mdio_o, mdio_oe     MDIO drive value and enable (tri-state built above)
//   link_up, speed_sel  status reflected in registers 1 and 17
//   ctrl_reg            register 0 contents
//   wr_stb, wr_addr,    one-clk pulse plus address/data of each accepted
//   wr_data             write
//
// state | meaning
// IDLE  | counting preamble ones, waiting for ST
// ST1   | second ST bit
// OP    | opcode, 2 bits
// PHYAD | PHY address, 5 bits
// REGAD | register address, 5 bits; read word latched on the last bit
// TA    | turnaround, 2 bits
// DATA  | 16 data bits, MSB first
module mdio_phy_resp #(
  parameter logic [4:0]  PHY_ADDR = 5'h04,
  parameter logic [15:0] ID1      = 16'h001C,
  parameter logic [15:0] ID2      = 16'hC916,
  parameter logic [15:0] CTRL_RST = 16'h1140
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        link_up,
  input  logic [1:0]  speed_sel,
  output logic [15:0] ctrl_reg,
  output logic        wr_stb,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data
);

  typedef enum logic [2:0] {IDLE, ST1, OP, PHYAD, REGAD, TA, DATA} state_t;

  state_t      state;
  logic [1:0]  mdc_s;
  logic [1:0]  mdio_s;
  logic        mdc_q;
  logic        rise;
  logic [5:0]  pre_cnt;
  logic [3:0]  cnt;
  logic        op_b;
  logic        is_read;
  logic        match;
  logic [3:0]  phy_sr;
  logic [4:0]  reg_sr;
  logic [14:0] wd_sr;
  logic [15:0] rd_sr;
  logic [15:0] scratch [0:11];

  logic        din;
  logic [4:0]  rd_addr;
  logic [3:0]  rd_idx;
  logic [3:0]  wr_idx;
  logic [15:0] rd_val;
  logic [15:0] wd_full;

  assign din     = mdio_s[1];
  // Address as it will be once the current (last) REGAD bit is shifted in.
  assign rd_addr = {reg_sr[3:0], din};
  assign rd_idx  = rd_addr[3:0] - 4'd4;
  assign wr_idx  = reg_sr[3:0] - 4'd4;
  assign wd_full = {wd_sr, din};

  always_comb begin
    rd_val = 16'h0000;
    case (rd_addr)
      5'd0:    rd_val = ctrl_reg;
      5'd1:    rd_val = 16'h7809 | {13'b0, link_up, 2'b00};
      5'd2:    rd_val = ID1;
      5'd3:    rd_val = ID2;
      5'd17:   rd_val = {speed_sel, 14'h0000};
      default: if (rd_addr >= 5'd4 && rd_addr <= 5'd15) rd_val = scratch[rd_idx];
    endcase
  end

  // Synchronizers and registered rising-edge detect on MDC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdc_s  <= 2'b00;
      mdio_s <= 2'b11;
      mdc_q  <= 1'b0;
      rise   <= 1'b0;
    end else begin
      mdc_s  <= {mdc_s[0], mdc};
      mdio_s <= {mdio_s[0], mdio_i};
      mdc_q  <= mdc_s[1];
      rise   <= mdc_s[1] & ~mdc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pre_cnt  <= 6'd0;
      cnt      <= 4'd0;
      op_b     <= 1'b0;
      is_read  <= 1'b0;
      match    <= 1'b0;
      phy_sr   <= 4'h0;
      reg_sr   <= 5'd0;
      wd_sr    <= 15'h0000;
      rd_sr    <= 16'h0000;
      mdio_o   <= 1'b1;
      mdio_oe  <= 1'b0;
      ctrl_reg <= CTRL_RST;
      wr_stb   <= 1'b0;
      wr_addr  <= 5'd0;
      wr_data  <= 16'h0000;
      for (int i = 0; i < 12; i++) scratch[i] <= 16'h0000;
    end else begin
      wr_stb <= 1'b0;
      if (rise) begin
        case (state)
          IDLE: begin
            if (din) begin
              if (pre_cnt != 6'd32) pre_cnt <= pre_cnt + 6'd1;
            end else begin
              if (pre_cnt == 6'd32) state <= ST1;
              pre_cnt <= 6'd0;
            end
          end
          ST1: begin
            cnt   <= 4'd0;
            state <= din ? OP : IDLE;
          end
          OP: begin
            op_b <= din;
            if (cnt == 4'd1) begin
              cnt <= 4'd0;
              if ({op_b, din} == 2'b10) begin
                is_read <= 1'b1;
                state   <= PHYAD;
              end else if ({op_b, din} == 2'b01) begin
                is_read <= 1'b0;
                state   <= PHYAD;
              end else begin
                state <= IDLE;
              end
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          PHYAD: begin
            phy_sr <= {phy_sr[2:0], din};
            if (cnt == 4'd4) begin
              match <= ({phy_sr, din} == PHY_ADDR);
              cnt   <= 4'd0;
              state <= REGAD;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          REGAD: begin
            reg_sr <= rd_addr;
            if (cnt == 4'd4) begin
              rd_sr <= rd_val;
              cnt   <= 4'd0;
              state <= TA;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          TA: begin
            if (cnt == 4'd0) begin
              if (is_read && match) begin
                mdio_oe <= 1'b1;
                mdio_o  <= 1'b0;
              end
              cnt <= 4'd1;
            end else begin
              if (is_read && match) begin
                mdio_o <= rd_sr[15];
                rd_sr  <= {rd_sr[14:0], 1'b0};
              end
              cnt   <= 4'd0;
              state <= DATA;
            end
          end
          DATA: begin
            wd_sr <= wd_full[14:0];
            if (cnt == 4'd15) begin
              state   <= IDLE;
              pre_cnt <= 6'd0;
              cnt     <= 4'd0;
              mdio_oe <= 1'b0;
              mdio_o  <= 1'b1;
              if (!is_read && match) begin
                wr_stb  <= 1'b1;
                wr_addr <= reg_sr;
                wr_data <= wd_full;
                if (reg_sr == 5'd0) begin
                  // Bit 15 is a soft reset: reload defaults, never stored.
                  ctrl_reg <= wd_full[15] ? CTRL_RST : wd_full;
                end else if (reg_sr >= 5'd4 && reg_sr <= 5'd15) begin
                  scratch[wr_idx] <= wd_full;
                end
              end
            end else begin
              if (is_read && match) begin
                mdio_o <= rd_sr[15];
                rd_sr  <= {rd_sr[14:0], 1'b0};
              end
              cnt <= cnt + 4'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdio_phy_resp.sv
module tb_mdio_phy_resp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mdc = 1'b0;
  logic        mdio_i = 1'b1;
  logic        mdio_o;
  logic        mdio_oe;
  logic        link_up = 1'b0;
  logic [1:0]  speed_sel = 2'b10;
  logic [15:0] ctrl_reg;
  logic        wr_stb;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;

  int checks = 0;
  int errors = 0;
  int stb_cnt = 0;

  mdio_phy_resp dut (
    .clk(clk), .rst_n(rst_n), .mdc(mdc), .mdio_i(mdio_i),
    .mdio_o(mdio_o), .mdio_oe(mdio_oe), .link_up(link_up),
    .speed_sel(speed_sel), .ctrl_reg(ctrl_reg), .wr_stb(wr_stb),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_stb) stb_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One MDC period: 5 clk low, 5 clk high; outputs sampled 5 clk after the rising pin edge.
  task automatic send_bit(input logic b);
    mdio_i = b;
    mdc = 1'b0;
    repeat (5) @(posedge clk);
    mdc = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  logic [15:0] rd;
  logic        oe13, oe14, ta, oe_end, oe_any;

  task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                       input logic [4:0] ra, input logic [15:0] wd);
    logic [31:0] v;
    v = {2'b01, op, phy, ra, 2'b10, wd};
    rd = 16'h0000; oe13 = 1'b0; oe14 = 1'b0; ta = 1'b1; oe_end = 1'b1; oe_any = 1'b0;
    for (int i = 0; i < pre; i++) begin
      send_bit(1'b1);
      oe_any |= mdio_oe;
    end
    for (int i = 0; i < 32; i++) begin
      send_bit((op == 2'b10 && i >= 14) ? 1'b1 : v[31-i]);
      oe_any |= mdio_oe;
      if (i == 13) oe13 = mdio_oe;
      if (i == 14) begin oe14 = mdio_oe; ta = mdio_o; end
      if (i >= 15 && i <= 30) rd[30-i] = mdio_o;
      if (i == 31) oe_end = mdio_oe;
    end
  endtask

  int s0;

  initial begin
    repeat (4) @(posedge clk);
    #1;
    chk("rst_oe", {31'b0, mdio_oe}, 32'd0);
    chk("rst_o", {31'b0, mdio_o}, 32'd1);
    chk("rst_ctrl", {16'b0, ctrl_reg}, 32'h1140);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("rst_stb", stb_cnt, 0);
    chk("rst_waddr", {27'b0, wr_addr}, 0);

    // Read ID1
    frame(32, 2'b10, 5'h04, 5'd2, 16'h0);
    chk("id1_oe13", {31'b0, oe13}, 0);
    chk("id1_oe14", {31'b0, oe14}, 1);
    chk("id1_ta", {31'b0, ta}, 0);
    chk("id1_data", {16'b0, rd}, 32'h001C);
    chk("id1_oe_end", {31'b0, oe_end}, 0);
    frame(32, 2'b10, 5'h04, 5'd3, 16'h0);
    chk("id2_data", {16'b0, rd}, 32'hC916);

    // Write reg 0
    s0 = stb_cnt;
    frame(32, 2'b01, 5'h04, 5'd0, 16'h0100);
    chk("w0_stb", stb_cnt - s0, 1);
    chk("w0_addr", {27'b0, wr_addr}, 0);
    chk("w0_data", {16'b0, wr_data}, 32'h0100);
    chk("w0_ctrl", {16'b0, ctrl_reg}, 32'h0100);
    frame(32, 2'b10, 5'h04, 5'd0, 16'h0);
    chk("r0_data", {16'b0, rd}, 32'h0100);
    frame(32, 2'b01, 5'h04, 5'd0, 16'h8000);
    chk("w0_softrst", {16'b0, ctrl_reg}, 32'h1140);
    frame(32, 2'b10, 5'h04, 5'd0, 16'h0);
    chk("r0_after_rst", {16'b0, rd}, 32'h1140);

    // Scratch write/read, RO write still strobes
    frame(32, 2'b01, 5'h04, 5'd15, 16'hA5C3);
    frame(32, 2'b10, 5'h04, 5'd15, 16'h0);
    chk("r15_data", {16'b0, rd}, 32'hA5C3);
    s0 = stb_cnt;
    frame(32, 2'b01, 5'h04, 5'd2, 16'h1234);
    chk("wro_stb", stb_cnt - s0, 1);
    chk("wro_addr", {27'b0, wr_addr}, 2);
    frame(32, 2'b10, 5'h04, 5'd2, 16'h0);
    chk("wro_keep", {16'b0, rd}, 32'h001C);
    frame(32, 2'b10, 5'h04, 5'd17, 16'h0);
    chk("r17_data", {16'b0, rd}, 32'h8000);
    frame(32, 2'b10, 5'h04, 5'd20, 16'h0);
    chk("r20_data", {16'b0, rd}, 32'h0000);

    // Wrong PHY address
    frame(32, 2'b10, 5'h05, 5'd1, 16'h0);
    chk("nomatch_oe", {31'b0, oe_any}, 0);
    s0 = stb_cnt;
    frame(32, 2'b01, 5'h05, 5'd4, 16'hBEEF);
    chk("nomatch_stb", stb_cnt - s0, 0);
    frame(32, 2'b10, 5'h04, 5'd4, 16'h0);
    chk("nomatch_r4", {16'b0, rd}, 32'h0000);

    // Short preamble ignored, bad opcode aborts
    frame(31, 2'b10, 5'h04, 5'd2, 16'h0);
    chk("pre31_oe", {31'b0, oe_any}, 0);
    frame(32, 2'b11, 5'h04, 5'd2, 16'h0);
    chk("op11_oe", {31'b0, oe_any}, 0);
    frame(32, 2'b10, 5'h04, 5'd2, 16'h0);
    chk("after_abort", {16'b0, rd}, 32'h001C);

    // Reset during DATA of a read of reg 1
    link_up = 1'b1;
    for (int i = 0; i < 32; i++) send_bit(1'b1);
    begin
      logic [15:0] hdr;
      hdr = {2'b01, 2'b10, 5'h04, 5'd1, 2'b11};
      for (int i = 0; i < 16; i++) send_bit(hdr[15-i]);
    end
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    chk("mid_oe_before", {31'b0, mdio_oe}, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_oe_rst", {31'b0, mdio_oe}, 0);
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    frame(32, 2'b10, 5'h04, 5'd1, 16'h0);
    chk("r1_link", {16'b0, rd}, 32'h780D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
